// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing a 2-cycle-latency dual-port RAM.
// Define RAMFIFO_LEVEL_EN to add the registered level/almost_full outputs.
module ram_fifo_ctrl #(
  parameter int AW = 7,
  parameter int DW = 8
`ifdef RAMFIFO_LEVEL_EN
  ,
  parameter int AFULL_THRESH = 120
`endif
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
`ifdef RAMFIFO_LEVEL_EN
  output logic [AW:0]   level,
  output logic          almost_full,
`endif
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_in,
  output logic [DW-1:0] ram_d,
  output logic [AW-1:0] ram_addr_out,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        v1_q, v1_d;
  logic        rv_q, rv_d;
  logic        wr_acc;
  logic        rd_acc;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) &&
                 (wp_q[AW] != rp_q[AW]);

  assign wr_acc = wr_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  assign ram_we       = wr_acc;
  assign ram_addr_in  = wp_q[AW-1:0];
  assign ram_d        = wr_data;
  assign ram_addr_out = rp_q[AW-1:0];

  assign rd_data  = ram_q;
  assign rd_valid = rv_q;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    v1_d = rd_acc;
    rv_d = v1_q;
    if (clr) begin
      wp_d = '0;
      rp_d = '0;
      rv_d = 1'b0;
    end else begin
      if (wr_acc) wp_d = wp_q + ONE;
      if (rd_acc) rp_d = rp_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wp_q <= '0;
      rp_q <= '0;
      v1_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      v1_q <= v1_d;
      rv_q <= rv_d;
    end
  end

`ifdef RAMFIFO_LEVEL_EN
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_THRESH);

  logic [AW:0] level_q, level_d;
  logic        af_q, af_d;

  // Track the count the pointers will hold after this edge.
  always_comb begin
    level_d = wp_d - rp_d;
    af_d    = (level_d >= AF_TH);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign level       = level_q;
  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural RAM and queue model.
// Covers directed plan items plus randomized traffic with flushes.
module tb_ram_fifo_ctrl;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetq = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, empty, rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_in, ram_addr_out;
  logic [DW-1:0] ram_d, ram_q;
`ifdef RAMFIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetq(resetq), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty),
`ifdef RAMFIFO_LEVEL_EN
    .level(level), .almost_full(almost_full),
`endif
    .ram_we(ram_we), .ram_addr_in(ram_addr_in), .ram_d(ram_d),
    .ram_addr_out(ram_addr_out), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM: registered read address, registered q.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_r;
  logic [DW-1:0] q_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_in] <= ram_d;
    ra_r <= ram_addr_out;
    q_r  <= mem[ra_r];
  end
  assign ram_q = q_r;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  logic [DW-1:0] mq[$];
  exp_t          exq[$];
  int            ecnt = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic step(bit w, logic [DW-1:0] d, bit r, bit c);
    bit wa, ra;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    wa = w && !c && (mq.size() < DEPTH);
    ra = r && !c && (mq.size() > 0);
    @(posedge clk);
    ecnt++;
    if (c) begin
      mq.delete();
      while (exq.size() > 0 && exq[$].due >= ecnt) void'(exq.pop_back());
    end else begin
      if (ra) exq.push_back('{due: ecnt + 1, d: mq.pop_front()});
      if (wa) mq.push_back(d);
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    mq.delete();
    exq.delete();
    @(posedge clk);
    ecnt++;
    #1;
    resetq = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  task automatic drain();
    int g = 0;
    while (mq.size() > 0 && g < 4 * DEPTH) begin
      step(0, '0, 1, 0);
      g++;
    end
    idle(3);
  endtask

  // Monitor: every cycle, rd_valid must match the scoreboard exactly.
  always @(negedge clk) begin
    if (exq.size() > 0 && exq[0].due < ecnt) begin
      chk("lost_read", 32'(exq[0].due), 32'(ecnt));
      void'(exq.pop_front());
    end
    if (exq.size() > 0 && exq[0].due == ecnt) begin
      chk("rd_valid_hi", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(exq[0].d));
      void'(exq.pop_front());
    end else begin
      chk("rd_valid_lo", 32'(rd_valid), 32'd0);
    end
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
`ifdef RAMFIFO_LEVEL_EN
    chk("level", 32'(level), 32'(mq.size()));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 120));
`endif
  end

  initial begin
    #2;
    do_reset();
    idle(2);

    // Three writes then three back-to-back reads.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    idle(3);

    // Fill to full, overflow write dropped, read everything back.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hAA, 0, 0);
    drain();

    // Full with simultaneous read/write for 300 cycles, across wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'(i + 7), 1, 0);
    drain();

    // Empty with simultaneous read/write: only the write lands.
    step(1, 8'h5C, 1, 0);
    step(0, '0, 1, 0);
    idle(3);

    // Accepted read killed by clr in the following cycle.
    step(1, 8'h61, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    idle(3);
    step(1, 8'h62, 0, 0);
    step(0, '0, 1, 0);
    idle(3);

    // Accepted read killed by reset in the following cycle.
    step(1, 8'h71, 0, 0);
    step(1, 8'h72, 0, 0);
    step(0, '0, 1, 0);
    do_reset();
    idle(3);
    step(1, 8'h73, 0, 0);
    step(0, '0, 1, 0);
    idle(3);

    // Level threshold crossing.
    for (int i = 0; i < 120; i++) step(1, 8'($urandom), 0, 0);
    idle(1);
    step(0, '0, 1, 0);
    idle(2);
    drain();

    // Randomized traffic with varying bias and rare flushes.
    for (int ph = 0; ph < 6; ph++) begin
      int wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
      for (int i = 0; i < 600; i++) begin
        step(($urandom % 100) < wp, 8'($urandom),
             ($urandom % 100) < 50, ($urandom % 200) == 0);
      end
    end
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
